lb_reg_bank: RTL

Parametrised local-bus register bank: the next-generation replacement for fixed four-register bus cores. It decodes a configurable window of 32-bit word registers on the `clk_lb` local bus and supports three register types per slot: read/write control, read-only hardware status, and sticky write-1-to-clear event flags. It also has configurable read latency and per-register write strobes. One instance sits behind the local-bus master per functional core; read-back is OR-combined with other bank instances.

---
 rtl/lb_reg_bank.sv | 162 ++++++++++++++++
 1 files changed

// File: rtl/lb_reg_bank.sv
// lb_reg_bank: parametrised local-bus register bank.
// Decodes a window of N_REGS 32-bit registers at BASE_ADDR. Each slot is read/write
// control, read-only hardware status, or sticky write-1-to-clear event flags.
// Reads return after RD_LAT clocks through a shift pipeline; read data is zero
// whenever it is not valid, so several banks can be OR-combined on one bus.
module lb_reg_bank #(
  parameter int unsigned          N_REGS    = 4,
  parameter logic [31:0]          BASE_ADDR = 32'h0000_0000,
  parameter int unsigned          RD_LAT    = 1,
  parameter logic [N_REGS*32-1:0] RST_VAL   = '0,
  parameter logic [N_REGS-1:0]    RO_MASK   = '0,
  parameter logic [N_REGS-1:0]    W1C_MASK  = '0,
  parameter bit                   ACK_MISS  = 1'b0
) (
  input  logic                   clk_lb,
  input  logic                   reset,
  input  logic                   lb_wr,
  input  logic                   lb_rd,
  input  logic [31:0]            lb_addr,
  input  logic [31:0]            lb_wr_d,
  output logic [31:0]            lb_rd_d,
  output logic                   lb_rd_rdy,
  input  logic [N_REGS*32-1:0]   hw_in,
  output logic [N_REGS*32-1:0]   reg_q,
  output logic [N_REGS-1:0]      wr_pulse
);

  // Index width; at least one bit so a single-register bank still decodes cleanly.
  localparam int unsigned DEC_BITS = (N_REGS > 2) ? $clog2(N_REGS) : 1;
  localparam int unsigned TAG_LSB  = DEC_BITS + 2;

  // ---------------------------------------------------------------------------
  // Address decode
  // ---------------------------------------------------------------------------
  logic [DEC_BITS-1:0] idx;
  logic                tag_hit;
  logic                idx_ok;
  logic                hit;
  logic                rd_ack;
  logic [N_REGS-1:0]   sel;
  logic [N_REGS-1:0]   wr_sel;

  assign idx     = lb_addr[DEC_BITS+1:2];
  assign tag_hit = (lb_addr[31:TAG_LSB] == BASE_ADDR[31:TAG_LSB]);
  // Window may be larger than N_REGS when N_REGS is not a power of two.
  assign idx_ok  = (32'(idx) < N_REGS);
  assign hit     = tag_hit && idx_ok;
  // Misses are only answered when this bank is configured to own them.
  assign rd_ack  = lb_rd && (hit || ACK_MISS);

  // One-hot register select for the current bus address, plus its write qualifier.
  always_comb begin
    sel    = '0;
    wr_sel = '0;
    for (int unsigned i = 0; i < N_REGS; i++) begin
      sel[i]    = hit && (idx == DEC_BITS'(i));
      wr_sel[i] = sel[i] && lb_wr;
    end
  end

  // ---------------------------------------------------------------------------
  // Register storage
  // ---------------------------------------------------------------------------
  logic [31:0] regs_q [N_REGS];
  logic [31:0] regs_d [N_REGS];

  // Next-state per slot type; RO slots hold no state and stay at zero.
  always_comb begin
    for (int unsigned i = 0; i < N_REGS; i++) begin
      regs_d[i] = regs_q[i];
      if (RO_MASK[i]) begin
        regs_d[i] = '0;
      end else if (W1C_MASK[i]) begin
        // Clear first, then OR in hardware sets so a same-cycle set wins.
        regs_d[i] = (regs_q[i] & ~(wr_sel[i] ? lb_wr_d : 32'h0)) | hw_in[i*32 +: 32];
      end else if (wr_sel[i]) begin
        regs_d[i] = lb_wr_d;
      end
    end
  end

  // Register state with asynchronous reset to RST_VAL (RO slots forced to zero).
  always_ff @(posedge clk_lb or posedge reset) begin
    if (reset) begin
      for (int unsigned i = 0; i < N_REGS; i++) begin
        regs_q[i] <= RO_MASK[i] ? 32'h0 : RST_VAL[i*32 +: 32];
      end
    end else begin
      for (int unsigned i = 0; i < N_REGS; i++) begin
        regs_q[i] <= regs_d[i];
      end
    end
  end

  // Flatten register contents onto the reg_q bus.
  always_comb begin
    reg_q = '0;
    for (int unsigned i = 0; i < N_REGS; i++) begin
      reg_q[i*32 +: 32] = regs_q[i];
    end
  end

  // ---------------------------------------------------------------------------
  // Write strobes
  // ---------------------------------------------------------------------------
  logic [N_REGS-1:0] wr_pulse_q;

  // One-clock strobe for every hit write, RO slots included.
  always_ff @(posedge clk_lb or posedge reset) begin
    if (reset) begin
      wr_pulse_q <= '0;
    end else begin
      wr_pulse_q <= wr_sel;
    end
  end

  assign wr_pulse = wr_pulse_q;

  // ---------------------------------------------------------------------------
  // Read path
  // ---------------------------------------------------------------------------
  logic [31:0] rd_word;

  // Read mux on pre-write state; RO slots return the live hardware input.
  always_comb begin
    rd_word = '0;
    for (int unsigned i = 0; i < N_REGS; i++) begin
      if (sel[i]) begin
        rd_word = RO_MASK[i] ? hw_in[i*32 +: 32] : regs_q[i];
      end
    end
  end

  logic [RD_LAT-1:0] rd_vld_q;
  logic [31:0]       rd_dat_q [RD_LAT];

  // RD_LAT-deep {valid, data} shift; reset drops anything in flight.
  always_ff @(posedge clk_lb or posedge reset) begin
    if (reset) begin
      rd_vld_q <= '0;
      for (int unsigned i = 0; i < RD_LAT; i++) begin
        rd_dat_q[i] <= '0;
      end
    end else begin
      rd_vld_q[0] <= rd_ack;
      // Data kept at zero unless valid so the bus can be OR-combined.
      rd_dat_q[0] <= rd_ack ? rd_word : 32'h0;
      for (int unsigned i = 1; i < RD_LAT; i++) begin
        rd_vld_q[i] <= rd_vld_q[i-1];
        rd_dat_q[i] <= rd_dat_q[i-1];
      end
    end
  end

  assign lb_rd_rdy = rd_vld_q[RD_LAT-1];
  assign lb_rd_d   = rd_dat_q[RD_LAT-1];

  // Byte-lane bits are ignored; hw_in slices of RW registers are unused.
  logic unused_in;
  assign unused_in = ^{lb_addr[1:0], hw_in};

endmodule
